fpmul_arbiter: RTL and testbench

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_pkg.sv | 11 +
 rtl/fpmul_rsp_fifo.sv | 50 +++++
 rtl/fpmul_arbiter.sv | 139 +++++++++++++
 tb/tb_fpmul_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared types and defaults for the two-requester FP multiplier arbiter.
// Shared by fpmul_arbiter and fpmul_rsp_fifo.
package fpmul_pkg;

    localparam int LATENCY_DEF   = 3;
    localparam int RSP_DEPTH_DEF = 2;

    typedef logic        req_id_t;
    typedef logic [31:0] fp32_t;

endpackage

// File: rtl/fpmul_rsp_fifo.sv
// First-word-fall-through response FIFO, one per requester.
// A write and a pop in the same cycle on a full FIFO both succeed.
module fpmul_rsp_fifo
    import fpmul_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  fp32_t wr_data,
    input  logic  rd_en,
    output logic  rd_valid,
    output fp32_t rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fp32_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign pop      = rd_en && rd_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency FP multiplier.
// Define FPMUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int LATENCY   = LATENCY_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic        busy
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]      cnt0;
    logic [CW-1:0]      cnt1;
    logic               elig0;
    logic               elig1;
    logic               gnt0;
    logic               gnt1;
    logic               acc;
    logic               pop0;
    logic               pop1;
    req_id_t            issue_id;
    logic [LATENCY-1:0] tag_v;
    req_id_t            tag_id [LATENCY];
    logic               wr0;
    logic               wr1;

    assign elig0 = req0_valid && (cnt0 < CW'(RSP_DEPTH));
    assign elig1 = req1_valid && (cnt1 < CW'(RSP_DEPTH));

`ifdef FPMUL_ARB_FIXED_PRIO_EN
    assign gnt0 = elig0;
    assign gnt1 = elig1 && !elig0;
`else
    // rr_ptr high means requester 1 wins the next tie
    logic rr_ptr;

    assign gnt0 = elig0 && (!elig1 || !rr_ptr);
    assign gnt1 = elig1 && (!elig0 || rr_ptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   rr_ptr <= 1'b0;
        else if (acc) rr_ptr <= gnt0;
    end
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign acc        = gnt0 || gnt1;
    assign pop0       = rsp0_valid && rsp0_ready;
    assign pop1       = rsp1_valid && rsp1_ready;
    assign busy       = (cnt0 != '0) || (cnt1 != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + CW'(gnt0) - CW'(pop0);
            cnt1 <= cnt1 + CW'(gnt1) - CW'(pop1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_id  <= 1'b0;
        end else begin
            mul_valid <= acc;
            if (acc) begin
                mul_a    <= gnt1 ? req1_a : req0_a;
                mul_b    <= gnt1 ? req1_b : req0_b;
                issue_id <= gnt1;
            end
        end
    end

    // Tag for an issue reaches the last stage as its product arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= 1'b0;
        end else begin
            tag_v[0]  <= mul_valid;
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign wr0 = tag_v[LATENCY-1] && (tag_id[LATENCY-1] == 1'b0);
    assign wr1 = tag_v[LATENCY-1] && (tag_id[LATENCY-1] == 1'b1);

    fpmul_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr0),
        .wr_data  (mul_result),
        .rd_en    (rsp0_ready),
        .rd_valid (rsp0_valid),
        .rd_data  (rsp0_data)
    );

    fpmul_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr1),
        .wr_data  (mul_result),
        .rd_en    (rsp1_ready),
        .rd_valid (rsp1_valid),
        .rd_data  (rsp1_data)
    );

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter: default instance plus a deep-FIFO
// instance used for the back-to-back streaming sequence.
module tb_fpmul_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, mul_valid, busy;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;

    logic        d_req0_ready, d_req1_ready, d_mul_valid, d_busy;
    logic [31:0] d_mul_a, d_mul_b, d_mul_result;
    logic        d_rsp0_valid, d_rsp1_valid;
    logic [31:0] d_rsp0_data, d_rsp1_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] pipe_n [LAT];
    logic [31:0] pipe_d [LAT];

    logic        collect = 1'b0;
    int          n_got = 0;
    logic [31:0] got_data [16];
    int          got_cyc [16];
    logic [31:0] exp_data [8];

    always #5 clk = ~clk;

    fpmul_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_ready(rsp1_ready),
        .busy(busy)
    );

    fpmul_arbiter #(.LATENCY(LAT), .RSP_DEPTH(8)) u_deep (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(d_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .mul_valid(d_mul_valid), .mul_a(d_mul_a), .mul_b(d_mul_b),
        .mul_result(d_mul_result),
        .rsp0_valid(d_rsp0_valid), .rsp0_data(d_rsp0_data),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(d_rsp1_valid), .rsp1_data(d_rsp1_data),
        .rsp1_ready(rsp1_ready),
        .busy(d_busy)
    );

    // Multiplier stand-in: one exact product, a scramble otherwise
    function automatic logic [31:0] fmodel(input logic [31:0] a,
                                           input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000)
            return 32'h40C0_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    always @(posedge clk) begin
        pipe_n[0] <= fmodel(mul_a, mul_b);
        pipe_d[0] <= fmodel(d_mul_a, d_mul_b);
        for (int i = 1; i < LAT; i++) begin
            pipe_n[i] <= pipe_n[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        cyc <= cyc + 1;
    end

    assign mul_result   = pipe_n[LAT-1];
    assign d_mul_result = pipe_d[LAT-1];

    always @(negedge clk) begin
        if (collect && d_rsp1_valid && n_got < 16) begin
            got_data[n_got] = d_rsp1_data;
            got_cyc[n_got]  = cyc;
            n_got++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0] pat [4];
        int         seen;

`ifdef FPMUL_ARB_FIXED_PRIO_EN
        pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b10;
`else
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
`endif

        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) tick();

        check("rst_mul_valid", 32'(mul_valid), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        // single operation, accept-to-response latency
        req0_valid = 1'b1;
        req0_a = 32'h4000_0000;
        req0_b = 32'h4040_0000;
        #1;
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("single_mul_valid", 32'(mul_valid), 32'd1);
        check("single_mul_a", mul_a, 32'h4000_0000);
        check("single_mul_b", mul_b, 32'h4040_0000);
        check("single_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check("single_rsp_early", 32'(rsp0_valid), 32'd0);
        tick();
        check("single_rsp_valid", 32'(rsp0_valid), 32'd1);
        check("single_rsp_data", rsp0_data, 32'h40C0_0000);
        tick();
        check("single_rsp_popped", 32'(rsp0_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);
        check("single_mul_hold", mul_a, 32'h4000_0000);

        // arbitration with both requesters streaming
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        req0_valid = 1'b1; req0_a = 32'h1111_0000; req0_b = 32'h0000_1111;
        req1_valid = 1'b1; req1_a = 32'h2222_0000; req1_b = 32'h0000_2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("arb_grant%0d", i),
                  {30'd0, req1_ready, req0_ready}, {30'd0, pat[i]});
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (12) tick();
        check("arb_drained", 32'(busy), 32'd0);

        // credit stall with rsp0 held off
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        req0_a = 32'h3F80_0000;
        req0_b = 32'h3F80_0001;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("stall_ready%0d", i), 32'(req0_ready),
                  (i < 2) ? 32'd1 : 32'd0);
            tick();
        end
        check("stall_rsp_valid", 32'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b1;
        #1;
        check("stall_still_full", 32'(req0_ready), 32'd0);
        tick();
        check("stall_resume", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        repeat (12) tick();
        check("stall_drained", 32'(busy), 32'd0);

        // reset while two operations are in flight
        req0_valid = 1'b1;
        req0_a = 32'h4000_0000;
        req0_b = 32'h4040_0000;
        repeat (2) tick();
        req0_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("midrst_mul_valid", 32'(mul_valid), 32'd0);
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("midrst_rsp0_data", rsp0_data, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp0_valid || rsp1_valid) seen++;
        end
        check("midrst_no_rsp", seen, 0);
        check("midrst_idle", 32'(busy), 32'd0);

        // back-to-back stream of 8 on requester 1, deep instance
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        collect = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req1_a = 32'h3F80_0000 + 32'(k);
            req1_b = 32'h4000_0000 + 32'(k << 4);
            exp_data[k] = fmodel(req1_a, req1_b);
            #1;
            check($sformatf("b2b_ready%0d", k), 32'(d_req1_ready), 32'd1);
            tick();
            check($sformatf("b2b_mul_valid%0d", k), 32'(d_mul_valid), 32'd1);
            check($sformatf("b2b_mul_a%0d", k), d_mul_a,
                  32'h3F80_0000 + 32'(k));
        end
        req1_valid = 1'b0;
        tick();
        check("b2b_mul_idle", 32'(d_mul_valid), 32'd0);
        repeat (12) tick();
        collect = 1'b0;
        check("b2b_count", n_got, 8);
        for (int k = 0; k < 8; k++) begin
            if (k < n_got)
                check($sformatf("b2b_data%0d", k), got_data[k], exp_data[k]);
        end
        if (n_got >= 8)
            check("b2b_span", got_cyc[7] - got_cyc[0], 7);
        check("b2b_idle", 32'(d_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
